arm_regfile_mp: RTL

Parametrised multi-port ARM register file that replaces the single-write, two-read 16x32 file. It provides two synchronous write ports (ALU result and load/base-writeback), three combinational read ports (Rn, Rm, Rs/Rd-for-store), and a dedicated program-counter register with auto-increment and the ARM read offset. It optionally forwards write data to the read ports in the same cycle. The block sits between instruction decode and the ALU/shifter in the datapath.

---
 rtl/arm_regfile_mp.sv | 61 ++++++
 1 files changed

// File: rtl/arm_regfile_mp.sv
// arm_regfile_mp: multi-port ARM register file (2 write ports W*, 3 comb read ports R*->A/B/C, PC with auto-increment, PC_OUT, WR_CONFLICT)
module arm_regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NREGS     = 16,
  parameter int PC_IDX    = 15,
  parameter int PC_STEP   = 4,
  parameter int PC_RD_OFS = 8,
  parameter int BYPASS    = 1
)(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              PC_EN,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] PC_OUT,
  output logic              WR_CONFLICT
);
  logic [DATA_W-1:0] mem [NREGS];
  logic [DATA_W-1:0] pc;
  logic w0, w1, p0, p1;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NREGS;
  endfunction
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return !ok(a) ? '0 :
           int'(a) == PC_IDX ? pc + DATA_W'(PC_RD_OFS) :
           (BYPASS != 0 && w1 && WA1 == a) ? WD1 :
           (BYPASS != 0 && w0 && WA0 == a) ? WD0 : mem[a];
  endfunction
  assign w0 = CLR && WE0 && ok(WA0);
  assign w1 = CLR && WE1 && ok(WA1);
  assign p0 = w0 && int'(WA0) == PC_IDX;
  assign p1 = w1 && int'(WA1) == PC_IDX;
  assign PC_OUT = pc;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) pc <= '0;
    else pc <= p1 ? WD1 : p0 ? WD0 : PC_EN ? pc + DATA_W'(PC_STEP) : pc;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else for (int i = 0; i < NREGS; i++)
      mem[i] <= (w1 && WA1 == ADDR_W'(i)) ? WD1 : (w0 && WA0 == ADDR_W'(i)) ? WD0 : mem[i];
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) WR_CONFLICT <= 1'b0;
    else WR_CONFLICT <= w0 && w1 && WA0 == WA1;
  always_comb begin
    A = rd(RA);
    B = rd(RB);
    C = rd(RC);
  end
endmodule
